// File: rtl/bmem_arb_pkg.sv
// Shared types and geometry for the cache-to-burst-memory arbiter.
// Line/beat sizes and the FSM state encoding live here so sibling arbiters agree.
package bmem_arb_pkg;

    localparam int NUM_CLIENTS = 4;
    localparam int ADDR_BITS   = 32;
    localparam int OFFSET_BITS = 5;
    localparam int LINE_BITS   = 256;
    localparam int BEAT_BITS   = 64;
    localparam int BEATS       = LINE_BITS / BEAT_BITS;
    localparam int BEAT_CNT_W  = $clog2(BEATS);
    localparam int TAG_BITS    = ADDR_BITS - OFFSET_BITS;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_REQ,
        RD_WAIT,
        RESP
    } arb_state_t;

    // Line-aligned byte address from a line tag.
    function automatic logic [ADDR_BITS-1:0] line_base(input logic [TAG_BITS-1:0] tag);
        return {tag, {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
// Produces both a one-hot grant and its binary index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);

    logic [IW-1:0] rot_idx [N];
    logic [N-1:0]  rot_req;

    // rot_req[k] is the requester k positions after ptr.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [IW:0] sum;
            assign sum         = {1'b0, ptr} + (IW+1)'(gi);
            assign rot_idx[gi] = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
            assign rot_req[gi] = req[rot_idx[gi]];
        end
    endgenerate

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                grant_valid = 1'b1;
                grant_idx   = rot_idx[i];
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bmem_arbiter.sv
// Round-robin arbiter between the cache clients and the single burst-memory port.
// One line transaction at a time, serialised into BEATS beats of BEAT_BITS.
module bmem_arbiter
    import bmem_arb_pkg::*;
#(
    parameter int NUM_CLIENTS_P = NUM_CLIENTS,
    parameter bit CHECK_EN      = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_CLIENTS_P*32-1:0]        cl_addr,
    input  logic [NUM_CLIENTS_P-1:0]           cl_read,
    input  logic [NUM_CLIENTS_P-1:0]           cl_write,
    input  logic [NUM_CLIENTS_P*LINE_BITS-1:0] cl_wdata,
    output logic [LINE_BITS-1:0]             cl_rdata,
    output logic [NUM_CLIENTS_P-1:0]           cl_resp,
    output logic [31:0]                      bmem_addr,
    output logic                             bmem_read,
    output logic                             bmem_write,
    output logic [BEAT_BITS-1:0]             bmem_wdata,
    input  logic                             bmem_ready,
    input  logic [31:0]                      bmem_raddr,
    input  logic [BEAT_BITS-1:0]             bmem_rdata,
    input  logic                             bmem_rvalid
);

    localparam int CW = (NUM_CLIENTS_P > 1) ? $clog2(NUM_CLIENTS_P) : 1;

    arb_state_t            state_reg, state_next;
    logic [CW-1:0]         rr_ptr_reg, rr_ptr_next;
    logic [CW-1:0]         grant_idx_reg, grant_idx_next;
    logic [BEAT_CNT_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic [TAG_BITS-1:0]   tag_reg, tag_next;
    logic [LINE_BITS-1:0]  line_reg, line_next;
    logic                  is_write_reg, is_write_next;

    logic [NUM_CLIENTS_P-1:0] arb_grant;
    logic [CW-1:0]          arb_idx;
    logic                   arb_valid;
    logic                   last_beat;
    logic                   raddr_match;

    rr_arbiter #(
        .N  (NUM_CLIENTS_P),
        .IW (CW)
    ) u_rr (
        .req         (cl_read | cl_write),
        .ptr         (rr_ptr_reg),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    assign last_beat   = (beat_cnt_reg == BEAT_CNT_W'(BEATS - 1));
    assign raddr_match = (bmem_raddr == line_base(tag_reg));

    always_comb begin
        state_next     = state_reg;
        rr_ptr_next    = rr_ptr_reg;
        grant_idx_next = grant_idx_reg;
        beat_cnt_next  = beat_cnt_reg;
        tag_next       = tag_reg;
        line_next      = line_reg;
        is_write_next  = is_write_reg;
        cl_rdata       = '0;
        cl_resp        = '0;
        bmem_addr      = '0;
        bmem_read      = 1'b0;
        bmem_write     = 1'b0;
        bmem_wdata     = '0;

        case (state_reg)
            IDLE: begin
                if (arb_valid) begin
                    grant_idx_next = arb_idx;
                    tag_next       = cl_addr[arb_idx*32 + OFFSET_BITS +: TAG_BITS];
                    line_next      = cl_wdata[arb_idx*LINE_BITS +: LINE_BITS];
                    // A client raising both read and write gets the write.
                    is_write_next  = cl_write[arb_idx];
                    beat_cnt_next  = '0;
                    rr_ptr_next    = (arb_idx == CW'(NUM_CLIENTS_P - 1)) ? '0 : arb_idx + 1'b1;
                    state_next     = cl_write[arb_idx] ? WR : RD_REQ;
                end
            end
            WR: begin
                bmem_write = 1'b1;
                bmem_addr  = line_base(tag_reg);
                bmem_wdata = line_reg[beat_cnt_reg*BEAT_BITS +: BEAT_BITS];
                if (bmem_ready) begin
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                    if (last_beat) begin
                        state_next = RESP;
                    end
                end
            end
            RD_REQ: begin
                bmem_read = 1'b1;
                bmem_addr = line_base(tag_reg);
                if (bmem_ready) begin
                    beat_cnt_next = '0;
                    state_next    = RD_WAIT;
                end
            end
            RD_WAIT: begin
                // Beats tagged with some other line are not ours; drop them.
                if (bmem_rvalid && raddr_match) begin
                    line_next[beat_cnt_reg*BEAT_BITS +: BEAT_BITS] = bmem_rdata;
                    beat_cnt_next = beat_cnt_reg + 1'b1;
                    if (last_beat) begin
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                cl_resp[grant_idx_reg] = 1'b1;
                cl_rdata   = is_write_reg ? '0 : line_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            grant_idx_reg <= '0;
            beat_cnt_reg  <= '0;
            tag_reg       <= '0;
            line_reg      <= '0;
            is_write_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rr_ptr_reg    <= rr_ptr_next;
            grant_idx_reg <= grant_idx_next;
            beat_cnt_reg  <= beat_cnt_next;
            tag_reg       <= tag_next;
            line_reg      <= line_next;
            is_write_reg  <= is_write_next;
        end
    end

    generate
        if (CHECK_EN) begin : g_chk
            always @(posedge clk) begin
                if (!rst && state_reg == RD_WAIT && bmem_rvalid) begin
                    assert (raddr_match)
                        else $error("bmem_arbiter: read beat with foreign raddr %h", bmem_raddr);
                end
            end
            genvar gi;
            for (gi = 0; gi < NUM_CLIENTS_P; gi++) begin : g_client
                always @(posedge clk) begin
                    if (!rst) begin
                        assert (!(cl_read[gi] && cl_write[gi]))
                            else $error("bmem_arbiter: client %0d read and write together", gi);
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter: table-driven write beat sequence plus
// hand-written read, round-robin, foreign-beat, reset-abort and read+write cases.
module tb_bmem_arbiter;
    import bmem_arb_pkg::*;

    localparam int N = 4;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N*32-1:0]        cl_addr;
    logic [N-1:0]           cl_read;
    logic [N-1:0]           cl_write;
    logic [N*LINE_BITS-1:0] cl_wdata;
    logic [LINE_BITS-1:0]   cl_rdata;
    logic [N-1:0]           cl_resp;
    logic [31:0]            bmem_addr;
    logic                   bmem_read;
    logic                   bmem_write;
    logic [BEAT_BITS-1:0]   bmem_wdata;
    logic                   bmem_ready;
    logic [31:0]            bmem_raddr;
    logic [BEAT_BITS-1:0]   bmem_rdata;
    logic                   bmem_rvalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bmem_arbiter #(
        .NUM_CLIENTS_P (N),
        .CHECK_EN      (1'b0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cl_addr     (cl_addr),
        .cl_read     (cl_read),
        .cl_write    (cl_write),
        .cl_wdata    (cl_wdata),
        .cl_rdata    (cl_rdata),
        .cl_resp     (cl_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    typedef struct {
        logic        ready;
        logic        exp_write;
        logic        exp_read;
        logic [63:0] exp_wdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_resp;
        logic        drop;
    } wr_vec_t;

    wr_vec_t wv [9];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_bmem_read"},  bmem_read,  '0);
        chk({tag, "_bmem_write"}, bmem_write, '0);
        chk({tag, "_bmem_addr"},  bmem_addr,  '0);
        chk({tag, "_bmem_wdata"}, bmem_wdata, '0);
        chk({tag, "_cl_resp"},    cl_resp,    '0);
        chk({tag, "_cl_rdata"},   cl_rdata,   '0);
    endtask

    // Waits (bounded) for the read command, accepts it, feeds 4 beats, checks the response.
    task automatic serve_read(input int cli, input logic [31:0] req_addr,
                              input logic [255:0] line, input bit inject_bad);
        logic [31:0] base;
        int waited;
        base   = {req_addr[31:5], 5'b0};
        waited = 0;
        while (bmem_read !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        chk("rd_cmd_seen", bmem_read, 1'b1);
        chk("rd_addr", bmem_addr, base);
        chk("rd_no_write", bmem_write, 1'b0);
        bmem_ready = 1'b1;
        step();
        chk("rd_single_pulse", bmem_read, 1'b0);
        for (int b = 0; b < 4; b++) begin
            if (inject_bad && b == 2) begin
                bmem_rvalid = 1'b1;
                bmem_raddr  = 32'h2000_0000;
                bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
                step();
                chk("rd_foreign_no_resp", cl_resp, '0);
            end
            bmem_rvalid = 1'b1;
            bmem_raddr  = base;
            bmem_rdata  = line[64*b +: 64];
            step();
            if (b < 3) chk("rd_no_early_resp", cl_resp, '0);
        end
        bmem_rvalid = 1'b0;
        chk("rd_resp", cl_resp, 4'b0001 << cli);
        chk("rd_rdata", cl_rdata, line);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] line;
        logic [255:0] cap;
        logic [31:0]  a;
        int           order [5];
        int           beats;
        logic [3:0]   resp_seen;
        bit           saw_read;

        wv[0] = '{1'b1, 1'b0, 1'b0, 64'h0, 32'h0, 4'h0, 1'b0};
        wv[1] = '{1'b1, 1'b1, 1'b0, 64'hAAAA_AAAA_AAAA_AAAA, 32'h3000_0040, 4'h0, 1'b0};
        wv[2] = '{1'b0, 1'b1, 1'b0, 64'hBBBB_BBBB_BBBB_BBBB, 32'h3000_0040, 4'h0, 1'b0};
        wv[3] = '{1'b1, 1'b1, 1'b0, 64'hBBBB_BBBB_BBBB_BBBB, 32'h3000_0040, 4'h0, 1'b0};
        wv[4] = '{1'b1, 1'b1, 1'b0, 64'hCCCC_CCCC_CCCC_CCCC, 32'h3000_0040, 4'h0, 1'b0};
        wv[5] = '{1'b0, 1'b1, 1'b0, 64'hDDDD_DDDD_DDDD_DDDD, 32'h3000_0040, 4'h0, 1'b0};
        wv[6] = '{1'b1, 1'b1, 1'b0, 64'hDDDD_DDDD_DDDD_DDDD, 32'h3000_0040, 4'h0, 1'b0};
        wv[7] = '{1'b1, 1'b0, 1'b0, 64'h0, 32'h0, 4'b1000, 1'b1};
        wv[8] = '{1'b1, 1'b0, 1'b0, 64'h0, 32'h0, 4'h0, 1'b0};

        rst         = 1'b1;
        cl_addr     = '0;
        cl_read     = '0;
        cl_write    = '0;
        cl_wdata    = '0;
        bmem_ready  = 1'b1;
        bmem_raddr  = '0;
        bmem_rdata  = '0;
        bmem_rvalid = 1'b0;
        step(); step(); step();
        chk_idle_outputs("reset");
        rst = 1'b0;
        step();

        // Single read, client 1.
        line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
        cl_addr[1*32 +: 32] = 32'h1000_0024;
        cl_read[1] = 1'b1;
        serve_read(1, 32'h1000_0024, line, 1'b0);
        cl_read[1] = 1'b0;
        step();
        chk("rd_resp_one_cycle", cl_resp, '0);

        // Write, client 3, with ready toggling.
        cl_addr[3*32 +: 32] = 32'h3000_0044;
        cl_wdata[3*LINE_BITS +: LINE_BITS] = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                              64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        cl_write[3] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bmem_ready = wv[i].ready;
            chk($sformatf("wr%0d_write", i), bmem_write, wv[i].exp_write);
            chk($sformatf("wr%0d_read", i),  bmem_read,  wv[i].exp_read);
            chk($sformatf("wr%0d_wdata", i), bmem_wdata, wv[i].exp_wdata);
            chk($sformatf("wr%0d_addr", i),  bmem_addr,  wv[i].exp_addr);
            chk($sformatf("wr%0d_resp", i),  cl_resp,    wv[i].exp_resp);
            if (wv[i].exp_resp != 4'h0) chk($sformatf("wr%0d_rdata", i), cl_rdata, '0);
            if (wv[i].drop) cl_write[3] = 1'b0;
            step();
        end
        bmem_ready = 1'b1;

        // All four read at once; client 0 re-requests right after its response.
        for (int c = 0; c < N; c++) begin
            cl_addr[c*32 +: 32] = 32'h5000_0000 + 32'(c) * 32'h100;
        end
        cl_read = 4'b1111;
        order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            line = {64'(k*4+3), 64'(k*4+2), 64'(k*4+1), 64'(k*4)} ^ {4{64'h0F0F_0000_0000_A5A5}};
            a    = 32'h5000_0000 + 32'(order[k]) * 32'h100;
            serve_read(order[k], a, line, 1'b0);
            cl_read[order[k]] = 1'b0;
            if (k == 0) cl_read[0] = 1'b1;
        end
        step();
        chk("rr_done_resp", cl_resp, '0);

        // Foreign-tagged beat in the middle of a read.
        cl_addr[0 +: 32] = 32'h6000_0040;
        cl_read[0] = 1'b1;
        line = {64'h8888_0000_0000_0004, 64'h8888_0000_0000_0003,
                64'h8888_0000_0000_0002, 64'h8888_0000_0000_0001};
        serve_read(0, 32'h6000_0040, line, 1'b1);
        cl_read[0] = 1'b0;
        step();

        // Reset after the second read beat.
        cl_addr[2*32 +: 32] = 32'h7000_0000;
        cl_read[2] = 1'b1;
        step();
        chk("rst_rd_cmd", bmem_read, 1'b1);
        step();
        for (int b = 0; b < 2; b++) begin
            bmem_rvalid = 1'b1;
            bmem_raddr  = 32'h7000_0000;
            bmem_rdata  = 64'h7777_0000_0000_0000 + 64'(b);
            step();
        end
        rst = 1'b1;
        cl_read[2] = 1'b0;
        bmem_rdata = 64'h7777_0000_0000_0002;
        step();
        chk_idle_outputs("rst_abort");
        rst = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bmem_rdata = 64'h7777_0000_0000_0003 + 64'(b);
            step();
            chk("rst_stale_no_resp", cl_resp, '0);
            chk("rst_stale_no_read", bmem_read, 1'b0);
        end
        bmem_rvalid = 1'b0;
        cl_read[2] = 1'b1;
        line = {64'h9999_0000_0000_0004, 64'h9999_0000_0000_0003,
                64'h9999_0000_0000_0002, 64'h9999_0000_0000_0001};
        serve_read(2, 32'h7000_0000, line, 1'b0);
        cl_read[2] = 1'b0;
        step();

        // Client 2 raises read and write together: the write is performed.
        cl_addr[2*32 +: 32] = 32'h7100_0000;
        cl_wdata[2*LINE_BITS +: LINE_BITS] = {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                                              64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101};
        cl_read[2]  = 1'b1;
        cl_write[2] = 1'b1;
        beats     = 0;
        resp_seen = '0;
        saw_read  = 1'b0;
        cap       = '0;
        for (int c = 0; c < 20 && resp_seen == 4'h0; c++) begin
            step();
            if (bmem_write) begin
                if (beats < 4) cap[64*beats +: 64] = bmem_wdata;
                beats++;
            end
            if (bmem_read) saw_read = 1'b1;
            resp_seen = cl_resp;
        end
        cl_read[2]  = 1'b0;
        cl_write[2] = 1'b0;
        chk("rw_beats", beats, 4);
        chk("rw_line", cap, {64'h0404_0404_0404_0404, 64'h0303_0303_0303_0303,
                             64'h0202_0202_0202_0202, 64'h0101_0101_0101_0101});
        chk("rw_no_read", saw_read, 1'b0);
        chk("rw_resp", resp_seen, 4'b0100);
        step();
        chk("rw_resp_one_cycle", cl_resp, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
